// File: rtl/matrix_feeder_if.sv
// Element stream into the feeder and load/handshake signals toward the matrix core.
// slave: feeder side. master: the upstream source and the core, or a bench standing in for both.
interface matrix_feeder_if #(
   parameter int DATA_W = 8
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              start_in;
   logic              valid_input;
   logic [DATA_W-1:0] X_load;
   logic              finish;

   modport master (
      output s_valid, s_data, finish,
      input  s_ready, start_in, valid_input, X_load
   );

   modport slave (
      input  s_valid, s_data, finish,
      output s_ready, start_in, valid_input, X_load
   );
endinterface

// File: rtl/matrix_feeder.sv
// Buffers upstream elements in a multi-matrix word FIFO and feeds each complete matrix to the core.
// Optional finish watchdog: define FEEDER_FINISH_TIMEOUT_EN.
module matrix_feeder #(
   parameter int DATA_W    = 8,
   parameter int WORDS     = 32,
   parameter int MATS      = 2,
   parameter int START_GAP = 3,
   parameter int TIMEOUT   = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   matrix_feeder_if.slave         bus,
   output logic [$clog2(MATS):0]  avail_mats,
   output logic [15:0]            mats_done,
   output logic                   busy,
   output logic                   err_timeout
);

   localparam int DEPTH = MATS * WORDS;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int BW    = $clog2(WORDS);
   localparam logic [BW-1:0] BeatLast = BW'(WORDS - 1);
   localparam logic [7:0]    GapLast  = 8'(START_GAP - 1);
   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

   if ((WORDS < 2) || ((WORDS & (WORDS - 1)) != 0) || (MATS < 1) || ((MATS & (MATS - 1)) != 0) ||
       (START_GAP < 0) || (START_GAP > 255) || (TIMEOUT < 1)) begin : g_param_check
      $error("matrix_feeder: illegal parameter set");
   end

   typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, GAP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     word_cnt;
   logic [BW-1:0]     part_cnt;
   logic [BW-1:0]     beat_cnt;
   logic [7:0]        gap_cnt;
   logic              wr_en;
   logic              rd_en;
   logic              mat_complete;
   logic              mat_launch;
   logic              finish_ack;
   logic              wd_expire;

   assign bus.s_ready     = (word_cnt < DepthCnt);
   assign wr_en           = bus.s_valid & bus.s_ready;
   assign rd_en           = (state == STREAM);
   assign mat_complete    = wr_en && (part_cnt == BeatLast);
   assign finish_ack      = (state == WAIT) && bus.finish;
   assign mat_launch      = (state == IDLE) && (state_nxt == START);

   assign bus.start_in    = (state == START);
   assign bus.valid_input = rd_en;
   assign bus.X_load      = rd_en ? mem[rd_ptr] : '0;
   assign busy            = (state != IDLE);

`ifdef FEEDER_FINISH_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WdLast = WDW'(TIMEOUT - 1);

   logic [WDW-1:0] wd_cnt;

   // Watchdog only runs while waiting on finish; a real finish in the last cycle still wins.
   assign wd_expire = (state == WAIT) && !bus.finish && (wd_cnt == WdLast);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
         if (wd_expire)
            err_timeout <= 1'b1;
      end
   end
`else
   assign wd_expire   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Storage array carries no reset; only pointers and counts define its contents.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= bus.s_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_cnt <= '0;
         part_cnt <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr   <= wr_ptr + 1'b1;
            part_cnt <= part_cnt + 1'b1;
         end
         if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   word_cnt <= word_cnt + 1'b1;
            2'b01:   word_cnt <= word_cnt - 1'b1;
            default: word_cnt <= word_cnt;
         endcase
      end
   end

   // A matrix completing in the same cycle it is launched leaves avail_mats untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         avail_mats <= '0;
         mats_done  <= '0;
      end else begin
         case ({mat_complete, mat_launch})
            2'b10:   avail_mats <= avail_mats + 1'b1;
            2'b01:   avail_mats <= avail_mats - 1'b1;
            default: avail_mats <= avail_mats;
         endcase
         if (finish_ack)
            mats_done <= mats_done + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= (state == STREAM) ? beat_cnt + 1'b1 : '0;
         gap_cnt  <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      end
   end

   // IDLE also looks at a matrix completing this cycle so start_in follows the last word directly.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if ((avail_mats != '0) || mat_complete) state_nxt = START;
         START:  state_nxt = STREAM;
         STREAM: if (beat_cnt == BeatLast) state_nxt = WAIT;
         WAIT:   if (bus.finish || wd_expire) state_nxt = (START_GAP == 0) ? IDLE : GAP;
         GAP:    if (gap_cnt == GapLast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
